vga_scanout_reader: RTL and testbench

- Read side of the 320x240, 3-bit-colour framebuffer that the game's `draw` logic writes through the plot stream.
- Generates 640x480@60 VGA timing from the 50 MHz clock and fetches each 320x240 pixel, replicated 2x2, from framebuffer read port B.
- Drives the DAC outputs: RGB, HS, VS, BLANK_N, SYNC_N, VGA_CLK.
- Replaces the scan-out half of the vendor adapter so the team owns timing and can inject a test pattern.

---
 rtl/vga_scanout_reader.sv | 244 ++++++++++++++++++++++++
 tb/tb_vga_scanout_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_reader.sv
// vga_scanout_reader
// Read side of the 320x240, 3-bit-colour framebuffer. Generates 640x480@60
// VGA timing from the 50 MHz clock (one pixel every two clocks). Each
// framebuffer pixel is fetched and replicated 2x2 onto the screen. The DAC
// outputs are then driven from registers.
//
// Pipeline per pixel tick (pix_en):
//   tick N   : counters hold (h,v); fetch issued (fb_addr/fb_rd_en registered),
//              and sync/blank for (h,v) captured in stage 1
//   tick N+1 : fb_rd_data (valid one clock after fb_rd_en) and stage 1 are
//              registered into the DAC outputs, so RGB/HS/VS/BLANK_N align
//
// Ports:
//   clock, reset        50 MHz clock, asynchronous active-high reset
//   fb_addr, fb_rd_en   framebuffer read port B address / one-clock strobe
//   fb_rd_data          {R,G,B} returned one clock after fb_rd_en
//   vga_r/g/b           10-bit channels, colour bit replicated on all bits
//   vga_hs, vga_vs      active-low syncs
//   vga_blank_n         high during the visible region
//   vga_sync_n          held at 1
//   vga_clk             25 MHz pixel clock (the pixel phase bit)
//   frame_start         one-clock pulse when pixel (0,0) reaches the outputs
//   test_mode           selects the colour-bar pattern
//
// Optional feature macro: SCANOUT_TEST_PATTERN_EN. When defined, test_mode=1
// replaces framebuffer data with 8 vertical colour bars and suppresses reads.
// When undefined, test_mode is ignored.
module vga_scanout_reader #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FB_WIDTH  = 320,
  parameter int ADDR_BITS = 17
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ADDR_BITS-1:0] fb_addr,
  output logic                 fb_rd_en,
  input  logic [2:0]           fb_rd_data,
  output logic [9:0]           vga_r,
  output logic [9:0]           vga_g,
  output logic [9:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 vga_sync_n,
  output logic                 vga_clk,
  output logic                 frame_start,
  input  logic                 test_mode
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int BAR_W   = H_VISIBLE / 8;

  localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_C    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST_C = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST_C  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST_C = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST_C  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Bar index = x / BAR_W as a compare chain (no divider).
  function automatic logic [2:0] bar_colour(input logic [9:0] x);
    logic [2:0] c;
    if      (x < 10'(BAR_W * 1)) c = 3'd0;
    else if (x < 10'(BAR_W * 2)) c = 3'd1;
    else if (x < 10'(BAR_W * 3)) c = 3'd2;
    else if (x < 10'(BAR_W * 4)) c = 3'd3;
    else if (x < 10'(BAR_W * 5)) c = 3'd4;
    else if (x < 10'(BAR_W * 6)) c = 3'd5;
    else if (x < 10'(BAR_W * 7)) c = 3'd6;
    else                         c = 3'd7;
    return c;
  endfunction

  logic                 phase_q, phase_d;
  logic [9:0]           h_count_q, h_count_d, v_count_q, v_count_d;
  logic [ADDR_BITS-1:0] fb_addr_q, fb_addr_d;
  logic                 fb_rd_en_q, fb_rd_en_d;
  logic                 vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic                 first1_q, first1_d, tp_sel1_q, tp_sel1_d;
  logic [2:0]           tp_colour1_q, tp_colour1_d;
  logic [2:0]           rgb_q, rgb_d;
  logic                 hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic                 sync_n_q, sync_n_d, frame_start_q, frame_start_d;

  logic                 pix_en_s, visible_s, hs_win_s, vs_win_s, tp_sel_s;
  logic [7:0]           fb_y_s;
  logic [8:0]           fb_x_s;
  logic [ADDR_BITS-1:0] row_base_s, pix_addr_s;

`ifdef SCANOUT_TEST_PATTERN_EN
  assign tp_sel_s = test_mode;
`else
  logic test_mode_unused_s;
  assign tp_sel_s           = 1'b0;
  assign test_mode_unused_s = test_mode;
`endif

  assign pix_en_s  = phase_q;
  assign visible_s = (h_count_q < H_VIS_C) && (v_count_q < V_VIS_C);
  assign hs_win_s  = (h_count_q >= HS_FIRST_C) && (h_count_q <= HS_LAST_C);
  assign vs_win_s  = (v_count_q >= VS_FIRST_C) && (v_count_q <= VS_LAST_C);

  // Framebuffer coordinates are the screen coordinates halved (2x2 replication).
  assign fb_y_s = v_count_q[8:1];
  assign fb_x_s = h_count_q[9:1];

  // y*320 = (y<<8) + (y<<6); other row lengths fall back to a constant multiply.
  if (FB_WIDTH == 320) begin : g_row_shift
    assign row_base_s = (ADDR_BITS'(fb_y_s) << 4'd8) + (ADDR_BITS'(fb_y_s) << 4'd6);
  end else begin : g_row_mult
    assign row_base_s = ADDR_BITS'(ADDR_BITS'(fb_y_s) * FB_WIDTH);
  end

  assign pix_addr_s = row_base_s + ADDR_BITS'(fb_x_s);

  // Next-state for counters, fetch stage, stage-1 pipeline and output stage.
  always_comb begin
    phase_d       = ~phase_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    fb_addr_d     = fb_addr_q;
    fb_rd_en_d    = 1'b0;
    vis1_d        = vis1_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    first1_d      = first1_q;
    tp_sel1_d     = tp_sel1_q;
    tp_colour1_d  = tp_colour1_q;
    rgb_d         = rgb_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    sync_n_d      = 1'b1;
    frame_start_d = 1'b0;
    if (pix_en_s) begin
      if (h_count_q == H_LAST_C) begin
        h_count_d = 10'd0;
        if (v_count_q == V_LAST_C) begin
          v_count_d = 10'd0;
        end else begin
          v_count_d = v_count_q + 10'd1;
        end
      end else begin
        h_count_d = h_count_q + 10'd1;
      end

      // Fetch: address only moves when a read is issued.
      if (visible_s && !tp_sel_s) begin
        fb_rd_en_d = 1'b1;
        fb_addr_d  = pix_addr_s;
      end else begin
        fb_rd_en_d = 1'b0;
        fb_addr_d  = fb_addr_q;
      end

      vis1_d       = visible_s;
      hs1_d        = ~hs_win_s;
      vs1_d        = ~vs_win_s;
      first1_d     = (h_count_q == 10'd0) && (v_count_q == 10'd0);
      tp_sel1_d    = tp_sel_s;
      tp_colour1_d = bar_colour(h_count_q);

      // Output stage: fb_rd_data here belongs to the pixel fetched last tick.
      if (!vis1_q) begin
        rgb_d = 3'd0;
      end else if (tp_sel1_q) begin
        rgb_d = tp_colour1_q;
      end else begin
        rgb_d = fb_rd_data;
      end
      hs_d          = hs1_q;
      vs_d          = vs1_q;
      blank_n_d     = vis1_q;
      frame_start_d = first1_q;
    end else begin
      fb_rd_en_d    = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // State registers with asynchronous reset to the idle, blanked state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q       <= 1'b0;
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      fb_addr_q     <= '0;
      fb_rd_en_q    <= 1'b0;
      vis1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      first1_q      <= 1'b0;
      tp_sel1_q     <= 1'b0;
      tp_colour1_q  <= 3'd0;
      rgb_q         <= 3'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      sync_n_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
      vis1_q        <= vis1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      first1_q      <= first1_d;
      tp_sel1_q     <= tp_sel1_d;
      tp_colour1_q  <= tp_colour1_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      sync_n_q      <= sync_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_rd_en    = fb_rd_en_q;
  assign vga_r       = {10{rgb_q[2]}};
  assign vga_g       = {10{rgb_q[1]}};
  assign vga_b       = {10{rgb_q[0]}};
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = sync_n_q;
  assign vga_clk     = phase_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Directed testbench for vga_scanout_reader. Horizontal timing is the full
// 800-pixel line; the vertical dimensions are shrunk (6 visible lines, 12
// lines per frame) so whole frames fit in a short run. With that frame:
//   pixel p = v*800 + h is fetched on edge 2+2p and output on edge 4+2p,
//   a frame is 9600 pixels = 19200 clocks, VS is low for lines 8..9.
// The memory model returns fb_addr[2:0] one clock after fb_rd_en and 3'b111
// on every other clock.
module tb_vga_scanout_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic [16:0] fb_addr;
  logic        fb_rd_en;
  logic [2:0]  fb_rd_data;
  logic [9:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;
  logic        test_mode;

  int n_checks;
  int n_errors;

  always #10 clock = ~clock;

  vga_scanout_reader #(
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut (
    .clock(clock), .reset(reset),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_clk(vga_clk), .frame_start(frame_start),
    .test_mode(test_mode)
  );

  // Clock edges since reset release (edge 1 is the first posedge after).
  int unsigned cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Framebuffer read port model.
  always @(posedge clock) begin
    if (fb_rd_en) fb_rd_data <= fb_addr[2:0];
    else          fb_rd_data <= 3'b111;
  end

  // Edge recorders and event counters, sampled on the falling edge.
  int unsigned hs_fall0, hs_fall1, hs_rise0, vs_fall0, vs_fall1, vs_rise0;
  int unsigned n_hs_fall, n_vs_fall, n_hs_rise, n_vs_rise, rd_cnt, fs_cnt;
  logic hs_prev, vs_prev;
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      hs_fall0 <= 0; hs_fall1 <= 0; hs_rise0 <= 0;
      vs_fall0 <= 0; vs_fall1 <= 0; vs_rise0 <= 0;
      n_hs_fall <= 0; n_vs_fall <= 0; n_hs_rise <= 0; n_vs_rise <= 0;
      rd_cnt <= 0; fs_cnt <= 0;
      hs_prev <= 1'b1; vs_prev <= 1'b1;
    end else begin
      if (hs_prev && !vga_hs) begin
        if (n_hs_fall == 0) hs_fall0 <= cyc;
        if (n_hs_fall == 1) hs_fall1 <= cyc;
        n_hs_fall <= n_hs_fall + 1;
      end
      if (!hs_prev && vga_hs) begin
        if (n_hs_rise == 0) hs_rise0 <= cyc;
        n_hs_rise <= n_hs_rise + 1;
      end
      if (vs_prev && !vga_vs) begin
        if (n_vs_fall == 0) vs_fall0 <= cyc;
        if (n_vs_fall == 1) vs_fall1 <= cyc;
        n_vs_fall <= n_vs_fall + 1;
      end
      if (!vs_prev && vga_vs) begin
        if (n_vs_rise == 0) vs_rise0 <= cyc;
        n_vs_rise <= n_vs_rise + 1;
      end
      if (fb_rd_en && cyc <= 19200) rd_cnt <= rd_cnt + 1;
      if (frame_start) fs_cnt <= fs_cnt + 1;
      hs_prev <= vga_hs;
      vs_prev <= vga_vs;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the falling edge that follows posedge number e.
  task automatic wait_cyc(input int unsigned e);
    while (cyc < e) @(negedge clock);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    test_mode = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("rst_hs",      32'(vga_hs),      32'd1);
    check_eq("rst_vs",      32'(vga_vs),      32'd1);
    check_eq("rst_blank_n", 32'(vga_blank_n), 32'd0);
    check_eq("rst_rgb",     {2'b00, vga_r, vga_g, vga_b}, 32'd0);
    check_eq("rst_rd_en",   32'(fb_rd_en),    32'd0);
    check_eq("rst_sync_n",  32'(vga_sync_n),  32'd1);
    check_eq("rst_vga_clk", 32'(vga_clk),     32'd0);
    check_eq("rst_addr",    32'(fb_addr),     32'd0);
    reset = 1'b0;

    // First fetch and pixel tick.
    wait_cyc(1);  check_eq("c1_rd_en", 32'(fb_rd_en), 32'd0);
                  check_eq("c1_vga_clk", 32'(vga_clk), 32'd1);
    wait_cyc(2);  check_eq("c2_rd_en", 32'(fb_rd_en), 32'd1);
                  check_eq("c2_addr", 32'(fb_addr), 32'd0);
                  check_eq("c2_vga_clk", 32'(vga_clk), 32'd0);
    wait_cyc(3);  check_eq("c3_rd_en", 32'(fb_rd_en), 32'd0);
    wait_cyc(4);  check_eq("fs_first", 32'(frame_start), 32'd1);
                  check_eq("blank_first", 32'(vga_blank_n), 32'd1);
    wait_cyc(5);  check_eq("fs_one_clk", 32'(frame_start), 32'd0);

    // Address sequence on lines 0 and 2.
    wait_cyc(6);  check_eq("addr_2_0", 32'(fb_addr), 32'd1);
    wait_cyc(8);  check_eq("addr_3_0", 32'(fb_addr), 32'd1);

    // Colour mapping: pixel 10 -> addr 5 -> 101, pixel 12 -> addr 6 -> 110.
    wait_cyc(24); check_eq("rgb_101_r", 32'(vga_r), 32'h3FF);
                  check_eq("rgb_101_g", 32'(vga_g), 32'h000);
                  check_eq("rgb_101_b", 32'(vga_b), 32'h3FF);
                  check_eq("rgb_101_blank", 32'(vga_blank_n), 32'd1);
    wait_cyc(28); check_eq("rgb_110", {2'b00, vga_r, vga_g, vga_b}, {2'b00, 10'h3FF, 10'h3FF, 10'h000});

    wait_cyc(1280); check_eq("addr_639_0", 32'(fb_addr), 32'd319);
    wait_cyc(1282); check_eq("rd_en_blank", 32'(fb_rd_en), 32'd0);
                    check_eq("addr_hold", 32'(fb_addr), 32'd319);

    // Pixel 700 is blanked while memory drives 111.
    wait_cyc(1404); check_eq("blank_rgb", {2'b00, vga_r, vga_g, vga_b}, 32'd0);
                    check_eq("blank_n_700", 32'(vga_blank_n), 32'd0);
                    check_eq("hs_700", 32'(vga_hs), 32'd0);

    wait_cyc(3000); check_eq("hs_fall0", hs_fall0, 32'd1316);
                    check_eq("hs_rise0", hs_rise0, 32'd1508);
                    check_eq("hs_fall1", hs_fall1, 32'd2916);
    wait_cyc(3206); check_eq("addr_2_2", 32'(fb_addr), 32'd321);
    wait_cyc(9280); check_eq("addr_last", 32'(fb_addr), 32'd959);
    wait_cyc(19201); check_eq("rd_cnt_frame", rd_cnt, 32'd3840);
    wait_cyc(19202); check_eq("f1_rd_en", 32'(fb_rd_en), 32'd1);
                     check_eq("f1_addr", 32'(fb_addr), 32'd0);
    wait_cyc(19204); check_eq("fs_second", 32'(frame_start), 32'd1);
    wait_cyc(32010); check_eq("vs_fall0", vs_fall0, 32'd12804);
                     check_eq("vs_rise0", vs_rise0, 32'd16004);
                     check_eq("vs_fall1", vs_fall1, 32'd32004);
                     check_eq("fs_cnt", fs_cnt, 32'd2);

    // Reset at h=400, v=2 of the third frame, while vga_clk is high.
    wait_cyc(42401); check_eq("pre_vga_clk", 32'(vga_clk), 32'd1);
                     check_eq("pre_blank_n", 32'(vga_blank_n), 32'd1);
                     check_eq("pre_r", 32'(vga_r), 32'h3FF);
    reset = 1'b1;
    #1;
    check_eq("mid_vga_clk", 32'(vga_clk), 32'd0);
    check_eq("mid_blank_n", 32'(vga_blank_n), 32'd0);
    check_eq("mid_rgb", {2'b00, vga_r, vga_g, vga_b}, 32'd0);
    check_eq("mid_addr", 32'(fb_addr), 32'd0);
    check_eq("mid_hs_vs", {30'd0, vga_hs, vga_vs}, 32'd3);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wait_cyc(2);    check_eq("r2_rd_en", 32'(fb_rd_en), 32'd1);
                    check_eq("r2_addr", 32'(fb_addr), 32'd0);
    wait_cyc(3000); check_eq("r2_hs_fall0", hs_fall0, 32'd1316);
                    check_eq("r2_hs_fall1", hs_fall1, 32'd2916);

    // test_mode episode.
    reset     = 1'b1;
    test_mode = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
    wait_cyc(4);    check_eq("tp_bar0", {2'b00, vga_r, vga_g, vga_b}, 32'd0);
                    check_eq("tp_bar0_blank", 32'(vga_blank_n), 32'd1);
    wait_cyc(164);  check_eq("tp_bar1", {2'b00, vga_r, vga_g, vga_b}, {2'b00, 10'h000, 10'h000, 10'h3FF});
    wait_cyc(1124); check_eq("tp_bar7", {2'b00, vga_r, vga_g, vga_b}, {2'b00, 10'h3FF, 10'h3FF, 10'h3FF});
    wait_cyc(1600); check_eq("tp_rd_cnt", rd_cnt, 32'd0);
`else
    wait_cyc(24);   check_eq("tm_ignored_rgb", {2'b00, vga_r, vga_g, vga_b}, {2'b00, 10'h3FF, 10'h000, 10'h3FF});
    wait_cyc(1600); check_eq("tm_ignored_rd_cnt", rd_cnt, 32'd640);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
